// File: rtl/m68k_bus_initiator.sv
// Request/response front end that runs one 68000-style word bus cycle per accepted request,
// with a DTACK timeout in the strobe phase and a bounded wait for the responder to release.
module m68k_bus_initiator #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [22:0] req_addr,
   input  logic [1:0]  req_be,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic [22:0] bus_addr,
   output logic        bus_rw,
   output logic        bus_as_n,
   output logic        bus_uds_n,
   output logic        bus_lds_n,
   output logic [15:0] bus_dout,
   input  logic [15:0] bus_din,
   input  logic        bus_dtack_n,
   input  logic        bus_berr_n
);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, LATCH, RECOVER} state_t;

   state_t      state;
   logic [15:0] counter;
   logic        we;
   logic [1:0]  be;

   function automatic logic expired(input logic [15:0] count);
      return count == 16'(TIMEOUT);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         counter   <= '0;
         we        <= 1'b0;
         be        <= 2'b00;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         bus_addr  <= '0;
         bus_rw    <= 1'b1;
         bus_as_n  <= 1'b1;
         bus_uds_n <= 1'b1;
         bus_lds_n <= 1'b1;
         bus_dout  <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  we        <= req_we;
                  be        <= req_be;
                  bus_addr  <= req_addr;
                  bus_rw    <= ~req_we;
                  if (req_we) bus_dout <= req_wdata;
                  // No lanes enabled: report an error without touching the bus
                  if (req_be == 2'b00) begin
                     state     <= RECOVER;
                     counter   <= '0;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end else begin
                     state <= SETUP;
                  end
               end
            end
            SETUP: begin
               bus_as_n  <= 1'b0;
               bus_uds_n <= ~be[1];
               bus_lds_n <= ~be[0];
               counter   <= '0;
               state     <= STROBE;
            end
            STROBE: begin
               // Bus error outranks DTACK when both are seen on the same edge
               if (!bus_berr_n || (bus_dtack_n && expired(counter))) begin
                  bus_as_n  <= 1'b1;
                  bus_uds_n <= 1'b1;
                  bus_lds_n <= 1'b1;
                  bus_rw    <= 1'b1;
                  counter   <= '0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  state     <= RECOVER;
               end else if (!bus_dtack_n) begin
                  state <= LATCH;
               end else begin
                  counter <= counter + 16'd1;
               end
            end
            LATCH: begin
               if (!we) rsp_rdata <= bus_din;
               bus_as_n  <= 1'b1;
               bus_uds_n <= 1'b1;
               bus_lds_n <= 1'b1;
               bus_rw    <= 1'b1;
               counter   <= '0;
               rsp_valid <= 1'b1;
               state     <= RECOVER;
            end
            RECOVER: begin
               // Wait for the responder to release DTACK/BERR before the next cycle
               if ((bus_dtack_n && bus_berr_n) || expired(counter)) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
               end else begin
                  counter <= counter + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Directed bench for m68k_bus_initiator with a registered DTACK responder and bus monitors.
module tb_m68k_bus_initiator;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [22:0] req_addr;
   logic [1:0]  req_be;
   logic [15:0] req_wdata;
   logic        rsp_valid, rsp_err;
   logic [15:0] rsp_rdata;
   logic [22:0] bus_addr;
   logic        bus_rw, bus_as_n, bus_uds_n, bus_lds_n;
   logic [15:0] bus_dout;
   logic [15:0] bus_din;
   logic        bus_dtack_n = 1'b1;
   logic        bus_berr_n;
   logic        resp_en;

   int n_chk = 0, n_fail = 0;
   int cyc = 0, acc = 0, lat = 0;
   int as_cnt = 0, ds_cnt = 0, vld_cnt = 0, viol = 0;
   int snap_as, snap_ds, snap_vld;
   logic        prev_as_n = 1'b1, prev_rw = 1'b1;
   logic [22:0] prev_addr = '0;
   logic [15:0] prev_dout = '0;

   m68k_bus_initiator #(.TIMEOUT(8)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .bus_addr(bus_addr), .bus_rw(bus_rw), .bus_as_n(bus_as_n),
      .bus_uds_n(bus_uds_n), .bus_lds_n(bus_lds_n), .bus_dout(bus_dout),
      .bus_din(bus_din), .bus_dtack_n(bus_dtack_n), .bus_berr_n(bus_berr_n)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Zero-wait registered responder: DTACK follows AS one edge later
   always @(posedge clk) bus_dtack_n <= resp_en ? bus_as_n : 1'b1;

   always @(negedge clk) begin
      if (!bus_as_n) as_cnt = as_cnt + 1;
      if (!bus_uds_n || !bus_lds_n) ds_cnt = ds_cnt + 1;
      if (rsp_valid) vld_cnt = vld_cnt + 1;
      if (!prev_as_n && !bus_as_n &&
          (bus_addr !== prev_addr || bus_rw !== prev_rw || bus_dout !== prev_dout))
         viol = viol + 1;
      prev_as_n = bus_as_n;
      prev_addr = bus_addr;
      prev_rw   = bus_rw;
      prev_dout = bus_dout;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a request at a negedge; returns at the negedge after the accept edge
   task automatic issue(input logic we, input logic [22:0] addr, input logic [1:0] be,
                        input logic [15:0] wdata);
      chk("ready_before_req", req_ready, 1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_be    = be;
      req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0;
      acc = cyc;
      snap_as  = as_cnt;
      snap_ds  = ds_cnt;
      snap_vld = vld_cnt;
   endtask

   task automatic wait_rsp(output int l);
      int n = 0;
      while (!rsp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("rsp_valid_seen", rsp_valid, 1);
      l = cyc - acc;
   endtask

   task automatic wait_ready(output int l);
      int n = 0;
      while (!req_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("ready_seen", req_ready, 1);
      l = cyc - acc;
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = 2'b00;
      req_wdata = '0; bus_din = 16'h0000; bus_berr_n = 1'b1; resp_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_as_n", bus_as_n, 1);
      chk("rst_ds_n", {bus_uds_n, bus_lds_n}, 2'b11);
      chk("rst_rw", bus_rw, 1);
      chk("rst_addr", bus_addr, 0);
      chk("rst_dout", bus_dout, 0);
      chk("rst_rsp", {rsp_valid, rsp_err}, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_ready", req_ready, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", req_ready, 1);

      // Zero-wait read
      bus_din = 16'hBEEF;
      issue(1'b0, 23'h080000, 2'b11, 16'h0000);
      chk("rd_ready_low", req_ready, 0);
      chk("rd_setup_addr", bus_addr, 23'h080000);
      chk("rd_setup_rw", bus_rw, 1);
      chk("rd_setup_as_n", bus_as_n, 1);
      wait_rsp(lat);
      chk("rd_latency", lat, 4);
      chk("rd_rdata", rsp_rdata, 16'hBEEF);
      chk("rd_err", rsp_err, 0);
      chk("rd_as_cycles", as_cnt - snap_as, 3);
      @(negedge clk);
      chk("rd_valid_pulse", rsp_valid, 0);
      wait_ready(lat);
      chk("rd_idle_edge", lat, 6);

      // Lower-byte write
      issue(1'b1, 23'h000400, 2'b01, 16'h12A5);
      @(negedge clk);
      chk("wr_as_n", bus_as_n, 0);
      chk("wr_ds_n", {bus_uds_n, bus_lds_n}, 2'b10);
      chk("wr_rw", bus_rw, 0);
      chk("wr_dout", bus_dout, 16'h12A5);
      chk("wr_addr", bus_addr, 23'h000400);
      wait_rsp(lat);
      chk("wr_latency", lat, 4);
      chk("wr_err", rsp_err, 0);
      wait_ready(lat);

      // DTACK timeout
      resp_en = 1'b0;
      bus_din = 16'h5555;
      issue(1'b0, 23'h000123, 2'b10, 16'h0000);
      wait_rsp(lat);
      chk("to_latency", lat, 10);
      chk("to_err", rsp_err, 1);
      chk("to_rdata_kept", rsp_rdata, 16'hBEEF);
      chk("to_as_cycles", as_cnt - snap_as, 9);
      wait_ready(lat);

      // Bus error on the second strobe cycle
      issue(1'b0, 23'h000200, 2'b11, 16'h0000);
      repeat (2) @(negedge clk);
      bus_berr_n = 1'b0;
      @(negedge clk);
      chk("be_edge", cyc - acc, 3);
      chk("be_as_n", bus_as_n, 1);
      chk("be_ds_n", {bus_uds_n, bus_lds_n}, 2'b11);
      chk("be_rsp", {rsp_valid, rsp_err}, 2'b11);
      repeat (4) @(negedge clk);
      chk("be_hold_recover", req_ready, 0);
      bus_berr_n = 1'b1;
      wait_ready(lat);
      chk("be_idle_edge", lat, 8);
      chk("be_rdata_kept", rsp_rdata, 16'hBEEF);

      // No byte enables
      resp_en = 1'b1;
      issue(1'b0, 23'h000300, 2'b00, 16'h0000);
      chk("be00_rsp", {rsp_valid, rsp_err}, 2'b11);
      wait_ready(lat);
      chk("be00_idle_edge", lat, 1);
      chk("be00_no_strobes", (as_cnt - snap_as) + (ds_cnt - snap_ds), 0);

      // Reset while AS is asserted
      resp_en = 1'b0;
      issue(1'b1, 23'h000500, 2'b11, 16'hA5A5);
      @(negedge clk);
      chk("rm_as_low", bus_as_n, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("rm_strobes", {bus_as_n, bus_uds_n, bus_lds_n}, 3'b111);
      chk("rm_no_valid", rsp_valid, 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rm_vld_count", vld_cnt - snap_vld, 0);
      chk("rm_ready", req_ready, 1);

      chk("bus_stable_while_as", viol, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
